// File: rtl/button_pkg.sv
// Shared defaults and the debounce counter width helper for button_conditioner.
package button_pkg;

   localparam int NUM_BTN_DEFAULT         = 4;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

   // Width of a counter that only ever has to reach cycles-1.
   function automatic int cnt_width(input int cycles);
      return ($clog2(cycles) < 1) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchroniser, registered active-high sample,
// stable-sample counter, debounced level and one-cycle press/release pulses.
module btn_debounce_ch
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic raw_n,
   output logic level,
   output logic press,
   output logic release_pulse
);

   localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_q1;
   logic          sync_q2;
   logic          sample;
   logic [CW-1:0] cnt;
   logic          accept;

   // The sample register gives a full DEBOUNCE_CYCLES+2 edges from first capture to level change.
   assign accept = (sample != level) && (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1       <= 1'b1;
         sync_q2       <= 1'b1;
         sample        <= 1'b0;
         cnt           <= '0;
         level         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync_q1       <= raw_n;
         sync_q2       <= sync_q1;
         sample        <= ~sync_q2;
         press         <= accept && !level;
         release_pulse <= accept && level;
         if (sample == level) begin
            cnt <= '0;
         end else if (accept) begin
            cnt   <= '0;
            level <= ~level;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Debounces NUM_BTN active-low board keys into levels and press/release pulses.
// Define BTN_PRESS_COUNT_EN to add the 8-bit press_count and its count_clr input.
module button_conditioner
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int NUM_BTN         = NUM_BTN_DEFAULT
)
(
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic [NUM_BTN-1:0] btn_raw_n,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release
`ifdef BTN_PRESS_COUNT_EN
   ,
   input  logic               count_clr,
   output logic [7:0]         press_count
`endif
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk           (clk_clk),
         .rst_n         (reset_reset_n),
         .raw_n         (btn_raw_n[i]),
         .level         (btn_level[i]),
         .press         (btn_press[i]),
         .release_pulse (btn_release[i])
      );
   end

`ifdef BTN_PRESS_COUNT_EN
   logic [7:0] press_inc;

   always_comb begin
      press_inc = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         press_inc = press_inc + 8'(btn_press[i]);
      end
   end

   // A clear drops the history but still counts presses landing in the same cycle.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         press_count <= '0;
      end else if (count_clr) begin
         press_count <= press_inc;
      end else begin
         press_count <= press_count + press_inc;
      end
   end
`endif

endmodule
